// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiplier (signed N x N -> 2N) driving an external 4-bit iteration counter.
// Latency: start accept edge to done high is N+3 cycles; next start accepted at earliest N+4 cycles later.
// Backpressure: start is only sampled in IDLE; requests while busy or in DONE are dropped, not queued.
module booth_seq_ctrl #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  input  logic           cnt_zero,
  output logic           cnt_load,
  output logic [3:0]     cnt_load_value,
  output logic           cnt_dec,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  // A carries one guard bit so A+M / A-M cannot overflow, even for M = -2^(N-1).
  logic [N:0]       a_q, a_d;
  logic [N-1:0]     q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [N:0]       m_q, m_d;
  logic [2*N-1:0]   product_q, product_d;
  logic [N:0]       a_n;

  assign cnt_load_value = 4'(N);
  assign product        = product_q;

  // State and datapath registers, all cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      m_q       <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      m_q       <= m_d;
      product_q <= product_d;
    end
  end

  // Booth add/subtract selection from the two low bits of {Q, Q-1}.
  always_comb begin
    a_n = a_q;
    case ({q_q[0], qm1_q})
      2'b01:   a_n = a_q + m_q;
      2'b10:   a_n = a_q - m_q;
      default: a_n = a_q;
    endcase
  end

  // Next-state, datapath update and counter/handshake strobes.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    m_d       = m_q;
    product_d = product_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = {multiplicand[N-1], multiplicand};
          q_d     = multiplier;
          a_d     = '0;
          qm1_d   = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        busy     = 1'b1;
        cnt_load = 1'b1;
        state_d  = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (!cnt_zero) begin
          // Arithmetic right shift of {A_n, Q, Q-1}; A_n's sign bit is replicated.
          a_d     = {a_n[N], a_n[N:1]};
          q_d     = {a_n[0], q_q[N-1:1]};
          qm1_d   = q_q[0];
          cnt_dec = 1'b1;
        end else begin
          // Counter exhausted: the low N bits of A with Q form the full product.
          product_d = {a_q[N-1:0], q_q};
          state_d   = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Bench for booth_seq_ctrl with N=8 and a behavioural 4-bit iteration counter sharing rst.
// Expected products are queued at each accepted start and compared when done pulses.
// A per-cycle monitor checks handshake timing and the counter sequence against the start edge.
module tb_booth_seq_ctrl;
  localparam int N = 8;

  logic           clk;
  logic           rst;
  logic           start;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic           cnt_zero;
  logic           cnt_load;
  logic [3:0]     cnt_load_value;
  logic           cnt_dec;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  logic [3:0]     cnt;

  typedef struct {
    logic [2*N-1:0] prod;
    int             cyc0;
  } exp_t;

  exp_t exp_q[$];

  int vectors;
  int miscompares;
  int cyc;
  bit in_flight;
  int start_cyc;

  booth_seq_ctrl #(.N(N)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .multiplicand   (multiplicand),
    .multiplier     (multiplier),
    .cnt_zero       (cnt_zero),
    .cnt_load       (cnt_load),
    .cnt_load_value (cnt_load_value),
    .cnt_dec        (cnt_dec),
    .busy           (busy),
    .done           (done),
    .product        (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of the team's 4-bit iteration counter.
  always @(posedge clk) begin
    if (rst)                        cnt <= 4'd0;
    else if (cnt_load)              cnt <= cnt_load_value;
    else if (cnt_dec && cnt != 4'd0) cnt <= cnt - 4'd1;
  end
  assign cnt_zero = (cnt == 4'd0);

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] m, input logic [N-1:0] q);
    logic signed [2*N-1:0] p;
    p = $signed({{N{m[N-1]}}, m}) * $signed({{N{q[N-1]}}, q});
    return p;
  endfunction

  // Called #1 after the accept edge: record expectation for the operands that were sampled.
  task automatic push_exp(input logic [N-1:0] m, input logic [N-1:0] q);
    exp_t e;
    e.prod = ref_mul(m, q);
    e.cyc0 = cyc;
    exp_q.push_back(e);
    start_cyc = cyc;
    in_flight = 1'b1;
  endtask

  // Per-cycle monitor: lat is the cycle index relative to the accept edge (LOAD = 1).
  always @(negedge clk) begin
    int lat;
    exp_t e;
    if (!rst) begin
      check_val("ld_dec_excl", {31'd0, cnt_load & cnt_dec}, 32'd0);
      if (in_flight) begin
        lat = cyc - start_cyc + 1;
        if (lat >= 1 && lat <= N + 2) begin
          check_val("busy_hi", {31'd0, busy}, 32'd1);
          check_val("cnt_load", {31'd0, cnt_load}, {31'd0, lat == 1});
          check_val("done_early", {31'd0, done}, 32'd0);
        end
        if (lat >= 2 && lat <= N + 2) begin
          check_val("cnt_val", {28'd0, cnt}, 32'(N + 2 - lat));
          check_val("cnt_dec", {31'd0, cnt_dec}, {31'd0, lat <= N + 1});
        end
        if (done) begin
          check_val("done_lat", 32'(lat), 32'(N + 3));
          check_val("busy_in_done", {31'd0, busy}, 32'd0);
          if (exp_q.size() == 0) begin
            check_val("done_no_exp", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check_val("product", {16'd0, product}, {16'd0, e.prod});
          end
          in_flight = 1'b0;
        end else if (lat > N + 3) begin
          check_val("done_timeout", 32'(lat), 32'(N + 3));
          in_flight = 1'b0;
          void'(exp_q.pop_front());
        end
      end else begin
        check_val("idle_quiet", {28'd0, busy, cnt_load, cnt_dec, done}, 32'd0);
      end
    end
  end

  // One multiplication with start pulsed for a single cycle; operands scrambled while busy.
  task automatic run_op(input logic [N-1:0] m, input logic [N-1:0] q);
    int guard;
    @(negedge clk);
    start        = 1'b1;
    multiplicand = m;
    multiplier   = q;
    @(posedge clk);
    #1;
    push_exp(m, q);
    start        = 1'b0;
    multiplicand = N'($urandom);
    multiplier   = N'($urandom);
    guard = 0;
    while (in_flight && guard < 30) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (in_flight) check_val("run_op_hang", 32'd1, 32'd0);
  endtask

  initial begin
    logic [N-1:0] hm;
    logic [N-1:0] hq;
    vectors      = 0;
    miscompares  = 0;
    cyc          = 0;
    in_flight    = 1'b0;
    start_cyc    = 0;
    rst          = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_busy",    {31'd0, busy}, 32'd0);
    check_val("rst_done",    {31'd0, done}, 32'd0);
    check_val("rst_load",    {31'd0, cnt_load}, 32'd0);
    check_val("rst_dec",     {31'd0, cnt_dec}, 32'd0);
    check_val("rst_product", {16'd0, product}, 32'd0);
    check_val("load_value",  {28'd0, cnt_load_value}, 32'd8);

    // Basic signed product and the guard-bit corner cases.
    run_op(8'd3,    8'hFC);
    check_val("p_3x-4", {16'd0, product}, 32'h0000_FFF4);
    run_op(8'h80,   8'h80);
    check_val("p_-128x-128", {16'd0, product}, 32'h0000_4000);
    run_op(8'd127,  8'h80);
    check_val("p_127x-128", {16'd0, product}, 32'h0000_C080);
    run_op(8'h5A,   8'h00);
    run_op(8'h00,   8'h7F);
    check_val("p_0x7F", {16'd0, product}, 32'd0);

    // start held high with operands changing every cycle: accepts every N+4 cycles.
    @(negedge clk);
    start = 1'b1;
    hm = N'($urandom);
    hq = N'($urandom);
    multiplicand = hm;
    multiplier   = hq;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      push_exp(hm, hq);
      for (int c = 0; c < N + 4; c++) begin
        @(negedge clk);
        hm = N'($urandom);
        hq = N'($urandom);
        multiplicand = hm;
        multiplier   = hq;
      end
    end
    start = 1'b0;
    // Last accepted op still completes; wait it out.
    for (int g = 0; g < 30 && in_flight; g++) @(negedge clk);

    // Abort mid-RUN after four Booth steps.
    @(negedge clk);
    start        = 1'b1;
    multiplicand = 8'd100;
    multiplier   = 8'd77;
    @(posedge clk);
    #1;
    push_exp(8'd100, 8'd77);
    start = 1'b0;
    repeat (5) @(negedge clk);   // now in cycle 5, the fourth RUN step
    rst = 1'b1;
    @(posedge clk);
    #1;
    in_flight = 1'b0;
    void'(exp_q.pop_front());
    @(negedge clk);
    rst = 1'b0;
    check_val("abort_busy",    {31'd0, busy}, 32'd0);
    check_val("abort_done",    {31'd0, done}, 32'd0);
    check_val("abort_product", {16'd0, product}, 32'd0);
    check_val("abort_cnt",     {28'd0, cnt}, 32'd0);
    repeat (15) @(negedge clk);  // idle monitor flags any stray done
    run_op(8'hF9, 8'd9);
    check_val("p_-7x9", {16'd0, product}, 32'h0000_FFC1);

    // A few random operand pairs through the same scoreboard.
    for (int r = 0; r < 6; r++) run_op(N'($urandom), N'($urandom));

    repeat (3) @(negedge clk);
    check_val("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
